systolic_top: RTL and testbench
===============================

Name: systolic_top

Overview:
- Output-stationary signed integer matrix-multiply engine computing C = A x B, with A of size ROWS x K and B of size K x COLS.
- Operands arrive as flat packed buses. Computation uses a ROWS x COLS grid of multiply-accumulate PEs fed with skewed operand streams.
- A start/busy/done handshake wraps the computation, and the result is presented on a flat packed bus.
- It is the top-level compute block that host/control logic drives with one matrix job at a time.

Parameters:
- DATA_W, 8: operand element width, signed two's complement.
- ACC_W, 32: accumulator and result element width, signed.
- ROWS, 4: rows of A and C; PE grid height.
- COLS, 4: columns of B and C; PE grid width.
- K, 4: inner dimension; columns of A and rows of B.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  job request, sampled only in IDLE.
- busy  out  1  high while a job is latched or computing.
- done  out  1  one-cycle completion pulse.
- a_flat  in  ROWS*K*DATA_W  A[r][k] at bits [(r*K+k)*DATA_W +: DATA_W], signed.
- b_flat  in  K*COLS*DATA_W  B[k][c] at bits [(k*COLS+c)*DATA_W +: DATA_W], signed.
- c_flat  out  ROWS*COLS*ACC_W  C[r][c] at bits [(r*COLS+c)*ACC_W +: ACC_W], signed.

Behaviour:
- Reset: rst sampled high on a clk edge does all of the following, with priority over everything:
  - forces IDLE;
  - zeroes busy, done, c_flat, all accumulators, skew/pipeline registers and the step counter.
  - Reset mid-job aborts the job; no done pulse is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1:
    - latch a_flat and b_flat into internal operand registers;
    - clear all accumulators and pipeline registers;
    - set step counter=0, busy=1, and go to RUN.
  - Input changes after this edge do not affect the job.
- RUN:
  - Lasts exactly S = K+ROWS+COLS-2 cycles (10 for the defaults); the step counter t runs 0..S-1.
  - Row r of the left edge is injected with A[r][t-r] when 0 <= t-r < K, else 0.
  - Column c of the top edge is injected with B[t-c][c] when 0 <= t-c < K, else 0.
  - Each PE registers its a input to its right neighbour and its b input to its lower neighbour (one cycle per hop).
  - Each PE adds a*b to its own accumulator every cycle. PE(r,c) thus sums k = 0..K-1 of A[r][k]*B[k][c].
  - Zero padding guarantees no spurious contributions.
  - After the final RUN cycle, copy all accumulators into the c_flat output register and go to DONE.
- DONE:
  - Lasts one cycle: done=1, busy=0. Then return to IDLE.
  - Latency: done is high during the (S+1)th cycle after the start-accepting edge.
- c_flat: driven only from the output register.
  - Stable from the DONE cycle until the next job's DONE or reset.
  - Does not change during a subsequent RUN.
- start while busy (RUN or DONE) is ignored and is not queued.
- start held high continuously: a new job is accepted on the first IDLE edge after DONE.
- Arithmetic:
  - Product is a signed DATA_W x DATA_W multiply giving a 2*DATA_W result, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W with no saturation or overflow flag.
- done and busy are never high simultaneously.

Test Plan:
- Reset then A=identity, B[k][c]=k*4+c+1 -> done after 11 cycles; C equals B; busy high for the 10 RUN cycles only.
- A all 1, B all 1 -> every C element = 4. A all -128, B all -128 -> every C = 65536.
- A all -128, B all 127 -> every C = -65024. Random signed A/B -> C matches a software integer golden model for all 16 elements.
- Pulse start again 3 cycles after a job starts, and change a_flat mid-job -> ignored; the result reflects the latched operands; exactly one done pulse.
- Two back-to-back jobs -> c_flat holds job-1 results through job-2 RUN, then updates at job-2 done.
- Assert rst during RUN -> c_flat=0, busy=0, no done pulse; a new start afterwards completes correctly.

Source files
------------

// File: rtl/systolic_if.sv
// ---------------------------------------------------------------------------
// systolic_if -- job/operand/result bundle for the systolic matrix engine.
//
// Signals:
//   start   host -> engine  job request (taken only while the engine is idle)
//   busy    engine -> host  job running
//   done    engine -> host  one-cycle completion pulse
//   a_flat  host -> engine  A[r][k] at [(r*K+k)*DATA_W +: DATA_W], signed
//   b_flat  host -> engine  B[k][c] at [(k*COLS+c)*DATA_W +: DATA_W], signed
//   c_flat  engine -> host  C[r][c] at [(r*COLS+c)*ACC_W +: ACC_W], signed
// ---------------------------------------------------------------------------
interface systolic_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K      = 4
);
  logic                         start;
  logic                         busy;
  logic                         done;
  logic [ROWS*K*DATA_W-1:0]     a_flat;
  logic [K*COLS*DATA_W-1:0]     b_flat;
  logic [ROWS*COLS*ACC_W-1:0]   c_flat;

  modport master (output start, a_flat, b_flat, input  busy, done, c_flat);
  modport slave  (input  start, a_flat, b_flat, output busy, done, c_flat);
endinterface

// File: rtl/systolic_top.sv
// ---------------------------------------------------------------------------
// systolic_top -- output-stationary signed matrix multiply, C = A x B.
//
// A ROWS x COLS grid of MAC cells. A rows enter from the left edge and B
// columns from the top edge, each skewed by its row/column index so that
// A[r][k] and B[k][c] meet in cell (r,c) on the same cycle. Every cell keeps
// its own accumulator; the grid drains into the c_flat register at the end.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, aborts any job in flight
//   bus   slave side of systolic_if (start/busy/done, a_flat, b_flat, c_flat)
// ---------------------------------------------------------------------------
module systolic_top #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K      = 4
) (
  input  logic       clk,
  input  logic       rst,
  systolic_if.slave  bus
);

  // Cycles needed for the last operand pair to reach cell (ROWS-1, COLS-1).
  localparam int S      = K + ROWS + COLS - 2;
  localparam int STEP_W = $clog2(S + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic signed [DATA_W-1:0]   data_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic signed [2*DATA_W-1:0] prod_t;

  state_e                      state_q, state_d;
  logic [STEP_W-1:0]           step_q, step_d;
  logic [ROWS*K*DATA_W-1:0]    a_op_q, a_op_d;
  logic [K*COLS*DATA_W-1:0]    b_op_q, b_op_d;
  data_t                       a_pipe_q [ROWS][COLS];
  data_t                       a_pipe_d [ROWS][COLS];
  data_t                       b_pipe_q [ROWS][COLS];
  data_t                       b_pipe_d [ROWS][COLS];
  acc_t                        acc_q    [ROWS][COLS];
  acc_t                        acc_d    [ROWS][COLS];
  logic [ROWS*COLS*ACC_W-1:0]  c_q, c_d;

  // Operands seen by each cell this cycle, and their product.
  data_t                       a_in [ROWS][COLS];
  data_t                       b_in [ROWS][COLS];
  prod_t                       prod [ROWS][COLS];

  // Edge injection and neighbour links. Row r of A is delayed by r cycles
  // and column c of B by c cycles; outside the valid window the edge feeds
  // zero, so the padding cycles add nothing to any accumulator.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      if (int'(step_q) >= r && int'(step_q) < r + K)
        a_in[r][0] = a_op_q[(r*K + int'(step_q) - r)*DATA_W +: DATA_W];
      else
        a_in[r][0] = '0;
      for (int c = 1; c < COLS; c++)
        a_in[r][c] = a_pipe_q[r][c-1];
    end
    for (int c = 0; c < COLS; c++) begin
      if (int'(step_q) >= c && int'(step_q) < c + K)
        b_in[0][c] = b_op_q[((int'(step_q) - c)*COLS + c)*DATA_W +: DATA_W];
      else
        b_in[0][c] = '0;
      for (int r = 1; r < ROWS; r++)
        b_in[r][c] = b_pipe_q[r-1][c];
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        prod[r][c] = a_in[r][c] * b_in[r][c];
  end

  // Job sequencing and datapath next state.
  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    step_d   = step_q;
    a_op_d   = a_op_q;
    b_op_d   = b_op_q;
    a_pipe_d = a_pipe_q;
    b_pipe_d = b_pipe_q;
    acc_d    = acc_q;
    c_d      = c_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_op_d = bus.a_flat;
          b_op_d = bus.b_flat;
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
              a_pipe_d[r][c] = '0;
              b_pipe_d[r][c] = '0;
              acc_d[r][c]    = '0;
            end
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            a_pipe_d[r][c] = a_in[r][c];
            b_pipe_d[r][c] = b_in[r][c];
            // Signed size cast sign-extends the product; the sum wraps.
            acc_d[r][c]    = acc_q[r][c] + ACC_W'(prod[r][c]);
          end
        if (step_q == STEP_W'(S - 1)) begin
          // Capture includes this final cycle's products, hence acc_d.
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              c_d[(r*COLS + c)*ACC_W +: ACC_W] = acc_d[r][c];
          step_d  = '0;
          state_d = DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    if (rst) begin
      // NOTE: the pipeline and accumulator arrays are flops, not RAM, so
      // they are cleared here explicitly along with the scalar state.
      state_q <= IDLE;
      step_q  <= '0;
      a_op_q  <= '0;
      b_op_q  <= '0;
      c_q     <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          a_pipe_q[r][c] <= '0;
          b_pipe_q[r][c] <= '0;
          acc_q[r][c]    <= '0;
        end
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_op_q   <= a_op_d;
      b_op_q   <= b_op_d;
      c_q      <= c_d;
      a_pipe_q <= a_pipe_d;
      b_pipe_q <= b_pipe_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.c_flat = c_q;

endmodule

// File: tb/tb_systolic_top.sv
// ---------------------------------------------------------------------------
// tb_systolic_top -- directed self-checking bench for systolic_top.
// Drives and samples 1 ns after each rising edge; expected results come from
// hand-written constants or an integer matrix-multiply reference.
// ---------------------------------------------------------------------------
module tb_systolic_top;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int K      = 4;

  typedef int mat_t [4][4];

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  mat_t a_m, b_m, exp_c, exp1;

  systolic_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .K(K)) bus ();

  systolic_top #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ROWS(ROWS), .COLS(COLS), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic load_ops;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < K; k++)
        bus.a_flat[(r*K + k)*DATA_W +: DATA_W] = DATA_W'(a_m[r][k]);
    for (int k = 0; k < K; k++)
      for (int c = 0; c < COLS; c++)
        bus.b_flat[(k*COLS + c)*DATA_W +: DATA_W] = DATA_W'(b_m[k][c]);
  endtask

  task automatic golden;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int s;
        s = 0;
        for (int k = 0; k < K; k++) s += a_m[r][k] * b_m[k][c];
        exp_c[r][c] = s;
      end
  endtask

  task automatic fill(int av, int bv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = av;
        b_m[i][j] = bv;
      end
  endtask

  task automatic fill_const(int cv);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) exp_c[i][j] = cv;
  endtask

  task automatic fill_random;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j] = int'($urandom_range(0, 255)) - 128;
        b_m[i][j] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic check_c(string tag, mat_t e);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        check($sformatf("%s_c%0d%0d", tag, r, c),
              bus.c_flat[(r*COLS + c)*ACC_W +: ACC_W], e[r][c]);
  endtask

  // Entered on the sample after the accepting edge numbered cyc0 (1 = first
  // cycle after acceptance). Returns on the done sample or after a bound.
  task automatic wait_done(string tag, int cyc0, bit poke);
    int cyc;
    int bad;
    cyc = cyc0;
    bad = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy !== 1'b1) bad++;
      if (poke && cyc == 3) begin
        bus.start  = 1'b1;
        bus.a_flat = ~bus.a_flat;
      end
      if (poke && cyc == 4) bus.start = 1'b0;
      tick;
      cyc++;
    end
    check({tag, "_latency"}, cyc, 11);
    check({tag, "_busy_in_run"}, bad, 0);
    check({tag, "_busy_at_done"}, bus.busy, 0);
  endtask

  task automatic do_job(string tag, bit poke);
    load_ops;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    wait_done(tag, 1, poke);
    check_c(tag, exp_c);
    tick;
    check({tag, "_done_one_cycle"}, bus.done, 0);
    check({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    int dcnt;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    tick;
    tick;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cflat", {31'b0, |bus.c_flat}, 0);
    rst = 1'b0;
    tick;

    // Identity A: C must reproduce B exactly.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_m[i][j]   = (i == j) ? 1 : 0;
        b_m[i][j]   = i*4 + j + 1;
        exp_c[i][j] = i*4 + j + 1;
      end
    do_job("ident", 1'b0);

    fill(1, 1);       fill_const(4);      do_job("ones", 1'b0);
    fill(-128, -128); fill_const(65536);  do_job("negneg", 1'b0);
    fill(-128, 127);  fill_const(-65024); do_job("negpos", 1'b0);

    fill_random; golden; do_job("rand0", 1'b0);
    fill_random; golden; do_job("rand1", 1'b0);

    // Second start and an operand change during RUN are both ignored.
    fill_random; golden; do_job("poke", 1'b1);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) dcnt++;
      tick;
    end
    check("poke_not_queued", dcnt, 0);

    // Start held high: job 2 is taken on the first IDLE edge after DONE,
    // and c_flat keeps job 1's result until job 2 completes.
    fill_random; golden; load_ops;
    exp1 = exp_c;
    bus.start = 1'b1;
    tick;
    wait_done("hold1", 1, 1'b0);
    check_c("hold1", exp1);
    fill_random; golden; load_ops;
    tick;
    check("hold_idle_busy", bus.busy, 0);
    check("hold_idle_done", bus.done, 0);
    tick;
    bus.start = 1'b0;
    check("hold_restart_busy", bus.busy, 1);
    for (int i = 0; i < 4; i++) tick;
    check_c("hold_mid", exp1);
    wait_done("hold2", 5, 1'b0);
    check_c("hold2", exp_c);
    tick;

    // Reset during RUN aborts the job with no done pulse.
    fill_random; load_ops;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_cflat", {31'b0, |bus.c_flat}, 0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done !== 1'b0) dcnt++;
      tick;
    end
    check("abort_no_done", dcnt, 0);
    fill_random; golden; do_job("after_abort", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
